// File: rtl/leaf_out_arbiter.sv
// Credit-aware round-robin arbiter feeding a leaf's single BFT packet output.
// Each granted user word is wrapped as {valid, dst_leaf, dst_port, seq, payload}.
module leaf_out_arbiter #(
  parameter int NUM_OUT_PORTS         = 3,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int PACKET_BITS           = 49,
  parameter int CREDIT_BITS           = 8,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  bft_ready,
  input  logic                                  cfg_we,
  input  logic [2:0]                            cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dst_port,
  input  logic                                  cfg_en,
  input  logic                                  credit_vld,
  input  logic [2:0]                            credit_port
);

  localparam int PTR_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [PTR_W:0] NUM_P = (PTR_W+1)'(NUM_OUT_PORTS);
  localparam logic [31:0] CREDIT_MAX = 32'((64'(1) << CREDIT_BITS) - 64'(1));

  logic [NUM_OUT_PORTS-1:0] en_q;
  logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_q  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_q    [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
  logic [PTR_W-1:0]         rr_q, rr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;

  logic                     out_free;
  logic [NUM_OUT_PORTS-1:0] elig;
  logic [NUM_OUT_PORTS-1:0] gnt_oh;
  logic                     gnt_vld;
  logic [PTR_W:0]           sum;
  logic [PTR_W-1:0]         cand;
  logic [PTR_W:0]           nxt;

  // Saturating credit update: decrement for a grant, bulk add for a credit return.
  function automatic logic [CREDIT_BITS-1:0] credit_next(
    input logic [CREDIT_BITS-1:0] cur,
    input logic                   dec,
    input logic                   inc
  );
    logic [31:0] t;
    t = 32'(cur) - 32'(dec);
    if (inc) t = t + 32'(FREESPACE_UPDATE_SIZE);
    if (t > CREDIT_MAX) t = CREDIT_MAX;
    return t[CREDIT_BITS-1:0];
  endfunction

  // Round-robin search starting at rr_q; reset forces all acks low.
  always_comb begin
    out_free = !dout_q[PACKET_BITS-1] || bft_ready;
    elig     = '0;
    gnt_oh   = '0;
    gnt_vld  = 1'b0;
    sum      = '0;
    cand     = '0;
    nxt      = '0;
    rr_d     = rr_q;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      elig[i] = reset_n && out_free && vld_user2interface[i] && en_q[i] &&
                (credit_q[i] != '0);
    end
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      sum = {1'b0, rr_q} + (PTR_W+1)'(k);
      if (sum >= NUM_P) sum = sum - NUM_P;
      cand = sum[PTR_W-1:0];
      if (!gnt_vld && elig[cand]) begin
        gnt_vld      = 1'b1;
        gnt_oh[cand] = 1'b1;
        nxt          = {1'b0, cand} + (PTR_W+1)'(1);
        if (nxt == NUM_P) nxt = '0;
        rr_d         = nxt[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (out_free) dout_d = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (gnt_oh[i]) begin
        dout_d = {1'b1, leaf_q[i], dport_q[i], seq_q[i],
                  din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  assign ack_interface2user      = gnt_oh;
  assign dout_leaf_interface2bft = dout_q;

  // Port indices outside 0..NUM_OUT_PORTS-1 never match, so those writes drop out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_q <= '0;
      rr_q   <= '0;
      en_q   <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]   <= '0;
        dport_q[i]  <= '0;
        seq_q[i]    <= '0;
        credit_q[i] <= '0;
      end
    end else begin
      dout_q <= dout_d;
      rr_q   <= rr_d;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_next(credit_q[i], gnt_oh[i],
                                   credit_vld && (credit_port == 3'(i)));
        if (cfg_we && (cfg_port == 3'(i))) begin
          en_q[i]    <= cfg_en;
          leaf_q[i]  <= cfg_dst_leaf;
          dport_q[i] <= cfg_dst_port;
          seq_q[i]   <= '0;
        end else if (gnt_oh[i]) begin
          seq_q[i] <= seq_q[i] + NUM_ADDR_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Randomized and directed bench for leaf_out_arbiter against a cycle-level
// behavioural model of the arbitration, credit and sequence rules.
module tb_leaf_out_arbiter;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [95:0]  din;
  logic [2:0]   vld;
  logic [2:0]   ack;
  logic [48:0]  dout;
  logic         bft_ready;
  logic         cfg_we;
  logic [2:0]   cfg_port;
  logic [4:0]   cfg_dst_leaf;
  logic [3:0]   cfg_dst_port;
  logic         cfg_en;
  logic         credit_vld;
  logic [2:0]   credit_port;

  leaf_out_arbiter dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .dout_leaf_interface2bft (dout),
    .bft_ready               (bft_ready),
    .cfg_we                  (cfg_we),
    .cfg_port                (cfg_port),
    .cfg_dst_leaf            (cfg_dst_leaf),
    .cfg_dst_port            (cfg_dst_port),
    .cfg_en                  (cfg_en),
    .credit_vld              (credit_vld),
    .credit_port             (credit_port)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          m_en [N], m_leaf [N], m_dp [N], m_seq [N], m_cred [N];
  int          m_rr, m_g;
  logic [48:0] m_dout;
  logic [2:0]  exp_ack;
  logic [2:0]  last_ack;
  logic [2:0]  rr_obs [6];
  int          cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_leaf[i] = 0; m_dp[i] = 0; m_seq[i] = 0; m_cred[i] = 0;
    end
    m_rr = 0;
    m_dout = '0;
  endtask

  task automatic model_comb();
    m_g = -1;
    exp_ack = '0;
    if (reset_n && (!m_dout[48] || bft_ready)) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_rr + k) % N;
        if (m_g < 0 && vld[p] && m_en[p] != 0 && m_cred[p] > 0) m_g = p;
      end
    end
    if (m_g >= 0) exp_ack[m_g] = 1'b1;
  endtask

  task automatic model_seq();
    bit free;
    if (!reset_n) begin
      model_reset();
      return;
    end
    free = !m_dout[48] || bft_ready;
    if (m_g >= 0) begin
      m_dout = {1'b1, 5'(m_leaf[m_g]), 4'(m_dp[m_g]), 7'(m_seq[m_g]), din[m_g*32 +: 32]};
      m_seq[m_g]  = (m_seq[m_g] + 1) % 128;
      m_cred[m_g] = m_cred[m_g] - 1;
      m_rr        = (m_g + 1) % N;
    end else if (free) begin
      m_dout = '0;
    end
    if (credit_vld && credit_port < N) begin
      m_cred[credit_port] = m_cred[credit_port] + 64;
      if (m_cred[credit_port] > 255) m_cred[credit_port] = 255;
    end
    if (cfg_we && cfg_port < N) begin
      m_en[cfg_port]   = int'(cfg_en);
      m_leaf[cfg_port] = int'(cfg_dst_leaf);
      m_dp[cfg_port]   = int'(cfg_dst_port);
      m_seq[cfg_port]  = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_comb();
    last_ack = ack;
    chk("ack", 64'(ack), 64'(exp_ack));
    chk("dout", 64'(dout), 64'(m_dout));
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic cfg_credit(input int p, input int leaf, input int dp, input bit en);
    cfg_we = 1'b1; cfg_port = 3'(p); cfg_dst_leaf = 5'(leaf); cfg_dst_port = 4'(dp);
    cfg_en = en; credit_vld = 1'b1; credit_port = 3'(p);
    cycle();
    cfg_we = 1'b0; credit_vld = 1'b0;
  endtask

  task automatic credit_only(input int p);
    credit_vld = 1'b1; credit_port = 3'(p);
    cycle();
    credit_vld = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; din = '0; vld = '0; bft_ready = 1'b1;
    cfg_we = 1'b0; cfg_port = '0; cfg_dst_leaf = '0; cfg_dst_port = '0; cfg_en = 1'b0;
    credit_vld = 1'b0; credit_port = '0;
    model_reset();
    m_g = -1;
    cycle();
    cycle();
    reset_n = 1'b1;
    chk("rst_dout", 64'(dout), 64'd0);

    // Single word through port 0
    cfg_credit(0, 5, 2, 1'b1);
    din[31:0] = 32'hDEADBEEF;
    vld = 3'b001;
    cycle();
    chk("t1_ack", 64'(last_ack), 64'd1);
    chk("t1_pkt", 64'(dout), 64'({1'b1, 5'd5, 4'd2, 7'd0, 32'hDEADBEEF}));
    vld = '0;
    cycle();
    chk("t1_ack_drop", 64'(last_ack), 64'd0);

    // Round robin over all three ports from a fresh pointer
    do_reset();
    cfg_credit(0, 1, 1, 1'b1);
    cfg_credit(1, 7, 3, 1'b1);
    cfg_credit(2, 9, 4, 1'b1);
    vld = 3'b111;
    for (int i = 0; i < 6; i++) begin
      din = {$urandom, $urandom, $urandom};
      cycle();
      rr_obs[i] = last_ack;
      if (i >= 3) chk("rr_seq1", 64'(dout[38:32]), 64'd1);
    end
    for (int i = 0; i < 6; i++) chk("rr_order", 64'(rr_obs[i]), 64'(3'b001 << (i % 3)));

    // Back-pressure with a valid packet held
    bft_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = {$urandom, $urandom, $urandom};
      cycle();
      chk("stall_ack", 64'(last_ack), 64'd0);
    end
    bft_ready = 1'b1;
    cycle();
    chk("release_rr", 64'(last_ack), 64'd1);
    cycle();
    cycle();
    vld = '0;

    // Port 1 credit exhaustion and refill coinciding with a grant
    do_reset();
    cfg_credit(1, 3, 6, 1'b1);
    vld = 3'b010;
    cnt = 0;
    for (int i = 0; i < 63; i++) begin
      din = {$urandom, $urandom, $urandom};
      cycle();
      if (last_ack != 0) cnt++;
    end
    chk("cred_63", 64'(cnt), 64'd63);
    credit_only(1);
    chk("last_credit_ack", 64'(last_ack), 64'd2);
    cnt = 0;
    for (int i = 0; i < 66; i++) begin
      din = {$urandom, $urandom, $urandom};
      cycle();
      if (last_ack != 0) cnt++;
    end
    chk("refill_cnt", 64'(cnt), 64'd64);
    chk("starved", 64'(last_ack), 64'd0);
    vld = '0;

    // Sequence wrap on port 2, then cleared by reconfiguration
    cfg_credit(2, 11, 5, 1'b1);
    credit_only(2);
    credit_only(2);
    vld = 3'b100;
    for (int i = 0; i < 130; i++) begin
      din = {$urandom, $urandom, $urandom};
      cycle();
      if (i == 127) chk("seq127", 64'(dout[38:32]), 64'd127);
      if (i == 128) chk("seq_wrap", 64'(dout[38:32]), 64'd0);
    end
    vld = '0;
    cfg_we = 1'b1; cfg_port = 3'd2; cfg_dst_leaf = 5'd11; cfg_dst_port = 4'd5; cfg_en = 1'b1;
    cycle();
    cfg_we = 1'b0;
    vld = 3'b100;
    cycle();
    chk("seq_cleared", 64'(dout[38:32]), 64'd0);
    vld = '0;

    // Reset while a packet is stalled
    bft_ready = 1'b0;
    vld = 3'b100;
    cycle();
    reset_n = 1'b0;
    cycle();
    chk("rst_ack", 64'(last_ack), 64'd0);
    chk("rst_mid_dout", 64'(dout), 64'd0);
    reset_n = 1'b1;
    bft_ready = 1'b1;
    vld = 3'b111;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_ack", 64'(last_ack), 64'd0);
    end

    // Randomized traffic, config and credit returns (including out-of-range ports)
    for (int i = 0; i < 3000; i++) begin
      reset_n      = ($urandom_range(0, 599) != 0);
      din          = {$urandom, $urandom, $urandom};
      vld          = 3'($urandom);
      bft_ready    = ($urandom_range(0, 3) != 0);
      cfg_we       = ($urandom_range(0, 15) == 0);
      cfg_port     = 3'($urandom_range(0, 7));
      cfg_dst_leaf = 5'($urandom);
      cfg_dst_port = 4'($urandom);
      cfg_en       = ($urandom_range(0, 3) != 0);
      credit_vld   = ($urandom_range(0, 2) == 0);
      credit_port  = 3'($urandom_range(0, 7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
